// File: rtl/toggle_cover_drain.sv
// rtl/toggle_cover_drain.sv - first-hit toggle coverage scheduler with round-robin report drain
//
// Purpose:
//   Captures the first hit on each toggle point in sticky pending/claimed bitmaps.
//   It issues every newly covered point exactly once as an absolute cover index on a
//   valid/ready report channel, choosing round-robin among pending points. It also
//   counts how many distinct points have been claimed.
//
// Ports:
//   clock        in   1      rising-edge clock
//   reset        in   1      asynchronous active-high reset
//   valid        in   WIDTH  per-point hit pulses
//   clear        in   1      synchronous flush of all coverage state
//   out_valid    out  1      report available
//   out_ready    in   1      report channel accepts
//   out_index    out  IDX_W  absolute cover index of reported point
//   covered_cnt  out  CNT_W  distinct points claimed since reset/clear
//   all_covered  out  1      every point has been claimed
module toggle_cover_drain #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned IDX_W       = 32,
  parameter int unsigned CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] valid,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic [CNT_W-1:0] covered_cnt,
  output logic             all_covered
);

  localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] claimed;
  logic [PTR_W-1:0] ptr;

  logic             found;
  logic [PTR_W-1:0] sel;
  logic [PTR_W-1:0] cand_p;
  int unsigned      cand;
  logic [PTR_W-1:0] ptr_next;
  logic             load;
  logic [WIDTH-1:0] hits;
  logic [WIDTH-1:0] sel_mask;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] claimed_next;

  // Scan pending bits starting at ptr and wrapping; the first one found wins.
  always_comb begin
    found  = 1'b0;
    sel    = '0;
    cand   = 0;
    cand_p = '0;
    for (int k = 0; k < int'(WIDTH); k++) begin
      cand = int'(ptr) + k;
      if (cand >= WIDTH) begin
        cand = cand - WIDTH;
      end
      cand_p = PTR_W'(cand);
      if (!found && pending[cand_p]) begin
        found = 1'b1;
        sel   = cand_p;
      end
    end
  end

  assign ptr_next = (sel == PTR_W'(WIDTH - 1)) ? '0 : sel + PTR_W'(1);

  // The output register can take a new report when empty or when the current one
  // is being accepted this cycle.
  assign load = !clear && found && ((state == EMPTY) || out_ready);

  // Only bits never seen before become pending. A hit on the bit being selected
  // is already masked by its pending flag, so the claim always wins.
  assign hits         = valid & ~claimed & ~pending;
  assign sel_mask     = load ? (WIDTH'(1) << sel) : '0;
  assign pending_next = (pending & ~sel_mask) | hits;
  assign claimed_next = claimed | sel_mask;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= EMPTY;
      pending     <= '0;
      claimed     <= '0;
      ptr         <= '0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      covered_cnt <= '0;
    end else if (clear) begin
      // Flush drops any stalled report along with the coverage history.
      state       <= EMPTY;
      pending     <= '0;
      claimed     <= '0;
      ptr         <= '0;
      out_valid   <= 1'b0;
      out_index   <= '0;
      covered_cnt <= '0;
    end else begin
      pending <= pending_next;
      claimed <= claimed_next;
      if (load) begin
        state       <= FULL;
        out_valid   <= 1'b1;
        out_index   <= IDX_W'(COVER_INDEX) + IDX_W'(sel);
        covered_cnt <= covered_cnt + CNT_W'(1);
        ptr         <= ptr_next;
      end else if ((state == FULL) && out_ready) begin
        state     <= EMPTY;
        out_valid <= 1'b0;
      end
    end
  end

  assign all_covered = (covered_cnt == CNT_W'(WIDTH));

endmodule

// File: tb/tb_toggle_cover_drain.sv
// tb/tb_toggle_cover_drain.sv - self-checking bench for toggle_cover_drain
module tb_toggle_cover_drain;

  localparam int W     = 8;
  localparam int COVER = 100;

  logic         clock;
  logic         reset;
  logic [W-1:0] valid;
  logic         clear;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_index;
  logic [3:0]   covered_cnt;
  logic         all_covered;

  int tests = 0;
  int fails = 0;

  toggle_cover_drain #(.WIDTH(W), .COVER_INDEX(COVER), .IDX_W(32), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .valid(valid), .clear(clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
    .covered_cnt(covered_cnt), .all_covered(all_covered)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: sets of waiting/already-reported points, a round-robin start point,
  // and the report currently offered on the channel.
  bit m_wait [W];
  bit m_seen [W];
  int m_rr;
  bit m_full;
  int m_idx;
  int m_cnt;

  task automatic model_reset();
    for (int i = 0; i < W; i++) begin
      m_wait[i] = 0;
      m_seen[i] = 0;
    end
    m_rr = 0; m_full = 0; m_idx = 0; m_cnt = 0;
  endtask

  task automatic model_update(input logic [W-1:0] v, input logic c, input logic r);
    bit newhit [W];
    int pick;
    if (c) begin
      model_reset();
      return;
    end
    for (int i = 0; i < W; i++) newhit[i] = v[i] && !m_seen[i] && !m_wait[i];
    pick = -1;
    for (int k = 0; k < W; k++) begin
      if (pick < 0 && m_wait[(m_rr + k) % W]) pick = (m_rr + k) % W;
    end
    if (pick >= 0 && (!m_full || r)) begin
      m_wait[pick] = 0;
      m_seen[pick] = 1;
      m_cnt++;
      m_rr   = (pick + 1) % W;
      m_full = 1;
      m_idx  = COVER + pick;
    end else if (m_full && r) begin
      m_full = 0;
    end
    for (int i = 0; i < W; i++) if (newhit[i]) m_wait[i] = 1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Apply inputs across one rising edge; leaves time at the following falling edge.
  task automatic cycle(input logic [W-1:0] v, input logic c, input logic r);
    valid = v; clear = c; out_ready = r;
    @(posedge clock);
    model_update(v, c, r);
    @(negedge clock);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'(m_full));
    if (m_full) check({tag, "_index"}, 64'(out_index), 64'(m_idx));
    check({tag, "_cnt"}, 64'(covered_cnt), 64'(m_cnt));
    check({tag, "_all"}, 64'(all_covered), 64'(m_cnt == W));
  endtask

  typedef struct {
    logic [W-1:0] v;
    logic         clr;
    logic         rdy;
    logic         ev;
    int           eoff;
    int           ecnt;
  } vec_t;

  vec_t tbl [14];
  int   nrep;

  initial begin
    reset = 1'b1; valid = '0; clear = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_index", 64'(out_index), 64'd0);
    check("reset_cnt", 64'(covered_cnt), 64'd0);
    check("reset_all", 64'(all_covered), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    // Single hit then a full sweep, then repeated hits that must be ignored.
    tbl[0]  = '{8'h01, 0, 1, 0, 0, 0};
    tbl[1]  = '{8'h00, 0, 1, 1, 0, 1};
    tbl[2]  = '{8'h00, 0, 1, 0, 0, 1};
    tbl[3]  = '{8'hFF, 0, 1, 0, 0, 1};
    for (int i = 0; i < 7; i++) tbl[4 + i] = '{8'h00, 0, 1, 1, i + 1, i + 2};
    tbl[11] = '{8'h00, 0, 1, 0, 0, 8};
    tbl[12] = '{8'hFF, 0, 1, 0, 0, 8};
    tbl[13] = '{8'h00, 0, 1, 0, 0, 8};
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].v, tbl[i].clr, tbl[i].rdy);
      check($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) check($sformatf("tbl%0d_index", i), 64'(out_index), 64'(COVER + tbl[i].eoff));
      check($sformatf("tbl%0d_cnt", i), 64'(covered_cnt), 64'(tbl[i].ecnt));
      check($sformatf("tbl%0d_all", i), 64'(all_covered), 64'(tbl[i].ecnt == W));
    end

    // Stalled report holds while other hits arrive; drain follows round-robin order.
    cycle(8'h00, 1, 0);
    cycle(8'h08, 0, 0);
    check("stall_pre", 64'(out_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      cycle((i == 1) ? 8'h22 : 8'h00, 0, 0);
      check($sformatf("stall_hold%0d_v", i), 64'(out_valid), 64'd1);
      check($sformatf("stall_hold%0d_i", i), 64'(out_index), 64'(COVER + 3));
    end
    cycle(8'h00, 0, 1);
    check("rr_first_v", 64'(out_valid), 64'd1);
    check("rr_first_i", 64'(out_index), 64'(COVER + 5));
    cycle(8'h00, 0, 1);
    check("rr_second_v", 64'(out_valid), 64'd1);
    check("rr_second_i", 64'(out_index), 64'(COVER + 1));
    cycle(8'h00, 0, 1);
    check("rr_done_v", 64'(out_valid), 64'd0);
    check("rr_done_cnt", 64'(covered_cnt), 64'd3);

    // Same point hit continuously yields one report.
    cycle(8'h00, 1, 1);
    nrep = 0;
    for (int i = 0; i < 24; i++) begin
      cycle((i < 20) ? 8'h10 : 8'h00, 0, 1);
      if (out_valid) nrep++;
    end
    check("dup_reports", 64'(nrep), 64'd1);
    check("dup_cnt", 64'(covered_cnt), 64'd1);

    // Clear drops a stalled report and discards same-cycle hits.
    cycle(8'h00, 1, 0);
    cycle(8'h10, 0, 0);
    cycle(8'h00, 0, 0);
    check("clr_stalled_v", 64'(out_valid), 64'd1);
    check("clr_stalled_i", 64'(out_index), 64'(COVER + 4));
    cycle(8'h10, 1, 0);
    check("clr_drop_v", 64'(out_valid), 64'd0);
    check("clr_drop_cnt", 64'(covered_cnt), 64'd0);
    nrep = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(8'h00, 0, 1);
      if (out_valid) nrep++;
    end
    check("clr_no_bit4", 64'(nrep), 64'd0);
    cycle(8'h04, 0, 1);
    cycle(8'h00, 0, 1);
    check("clr_after_v", 64'(out_valid), 64'd1);
    check("clr_after_i", 64'(out_index), 64'(COVER + 2));
    check("clr_after_cnt", 64'(covered_cnt), 64'd1);

    // Asynchronous reset while a report is stalled.
    cycle(8'h00, 1, 0);
    cycle(8'h40, 0, 0);
    cycle(8'h00, 0, 0);
    check("arst_pre_v", 64'(out_valid), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_cnt", 64'(covered_cnt), 64'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Random traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] v;
      v = W'($urandom & $urandom & $urandom);
      cycle(v, ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0));
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
